// File: rtl/branch_ctrl.sv
// branch_ctrl: control-flow unit that feeds IF its Branch/Target/Halt inputs.
// Handles jump, conditional jump, call/return through a small return-address
// stack, and halt. Every taken transfer is followed by one flush slot.
// Optional feature: define BRANCH_CTRL_COUNT_EN to build the saturating
// taken-transfer counter; without it BranchCount is tied to zero.
module branch_ctrl #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             Init,
    input  logic [AW-1:0]                    PC,
    input  logic                             IsJmp,
    input  logic                             IsCall,
    input  logic                             IsRet,
    input  logic                             IsHalt,
    input  logic                             Cond,
    input  logic [AW-1:0]                    Addr,
    output logic                             Branch,
    output logic [AW-1:0]                    Target,
    output logic                             Halt,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   Depth,
    output logic                             StackErr,
    output logic [15:0]                      BranchCount
);

    localparam int            DW       = $clog2(RAS_DEPTH + 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(RAS_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALTED} state_t;

    state_t          state_reg, state_next;
    logic            branch_reg, branch_next;
    logic [AW-1:0]   target_reg, target_next;
    logic            halt_reg, halt_next;
    logic            err_reg, err_next;
    logic [DW-1:0]   depth_reg, depth_next;
    logic [AW-1:0]   ras_reg [RAS_DEPTH];
    logic [AW-1:0]   ras_top;
    logic [RAS_DEPTH-1:0] ras_wr;

    // Priority decode: only meaningful in RUN; FLUSH and HALTED ignore inputs.
    logic run, sel_halt, sel_ret, sel_call, sel_jmp;
    logic ras_empty, ras_full, push, pop, err_ret, err_call;

    assign run       = (state_reg == ST_RUN);
    assign sel_halt  = run & IsHalt;
    assign sel_ret   = run & ~IsHalt & IsRet;
    assign sel_call  = run & ~IsHalt & ~IsRet & IsCall;
    assign sel_jmp   = run & ~IsHalt & ~IsRet & ~IsCall & IsJmp & Cond;
    assign ras_empty = (depth_reg == '0);
    assign ras_full  = (depth_reg == DEPTH_MAX);
    assign push      = sel_call & ~ras_full;
    assign pop       = sel_ret & ~ras_empty;
    assign err_ret   = sel_ret & ras_empty;
    assign err_call  = sel_call & ras_full;

    // Top-of-stack read: the entry just below the occupancy pointer.
    always_comb begin
        ras_top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (depth_reg == DW'(i + 1)) begin
                ras_top = ras_reg[i];
            end
        end
    end

    // Per-entry write enables: a push lands at index Depth.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_wr
            assign ras_wr[gi] = push && (depth_reg == DW'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (Init) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: taken transfers go through one FLUSH slot, errors and halt park in HALTED.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (sel_halt || err_ret || err_call) begin
                    state_next = ST_HALTED;
                end else if (push || pop || sel_jmp) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH:  state_next = ST_RUN;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    // Output/datapath next values; Target keeps its last value when not branching.
    always_comb begin
        branch_next = push | pop | sel_jmp;
        target_next = target_reg;
        if (pop) begin
            target_next = ras_top + ADDR_ONE;
        end else if (push || sel_jmp) begin
            target_next = Addr + ADDR_ONE;
        end
        halt_next  = (state_reg == ST_HALTED) | sel_halt | err_ret | err_call;
        err_next   = err_reg | err_ret | err_call;
        depth_next = depth_reg;
        if (push) begin
            depth_next = depth_reg + DEPTH_ONE;
        end else if (pop) begin
            depth_next = depth_reg - DEPTH_ONE;
        end
    end

    // Registered outputs and stack pointer.
    always_ff @(posedge CLK) begin
        if (Init) begin
            branch_reg <= 1'b0;
            target_reg <= '0;
            halt_reg   <= 1'b0;
            err_reg    <= 1'b0;
            depth_reg  <= '0;
        end else begin
            branch_reg <= branch_next;
            target_reg <= target_next;
            halt_reg   <= halt_next;
            err_reg    <= err_next;
            depth_reg  <= depth_next;
        end
    end

    // Stack storage: contents above Depth are don't-care, so no reset.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (ras_wr[i]) begin
                ras_reg[i] <= PC + ADDR_ONE;
            end
        end
    end

`ifdef BRANCH_CTRL_COUNT_EN
    logic [15:0] count_reg;

    // Saturating count of cycles with Branch asserted.
    always_ff @(posedge CLK) begin
        if (Init) begin
            count_reg <= 16'h0;
        end else if (branch_reg && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign BranchCount = count_reg;
`else
    assign BranchCount = 16'h0;
`endif

    assign Branch   = branch_reg;
    assign Target   = target_reg;
    assign Halt     = halt_reg;
    assign Depth    = depth_reg;
    assign StackErr = err_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model (queue-based return stack).
module tb_branch_ctrl;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Init = 1'b0;
    logic [7:0]  PC = 8'h0;
    logic        IsJmp = 1'b0, IsCall = 1'b0, IsRet = 1'b0, IsHalt = 1'b0, Cond = 1'b0;
    logic [7:0]  Addr = 8'h0;
    logic        Branch;
    logic [7:0]  Target;
    logic        Halt;
    logic [2:0]  Depth;
    logic        StackErr;
    logic [15:0] BranchCount;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  pc_m = 8'h0;
    logic        exp_b = 1'b0, exp_h = 1'b0, exp_e = 1'b0;
    logic [7:0]  exp_t = 8'h0;
    logic [15:0] exp_cnt = 16'h0;
    logic [7:0]  ras_q[$];

    branch_ctrl #(.AW(8), .RAS_DEPTH(DEPTH)) dut (
        .CLK(CLK), .Init(Init), .PC(PC), .IsJmp(IsJmp), .IsCall(IsCall),
        .IsRet(IsRet), .IsHalt(IsHalt), .Cond(Cond), .Addr(Addr),
        .Branch(Branch), .Target(Target), .Halt(Halt), .Depth(Depth),
        .StackErr(StackErr), .BranchCount(BranchCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; model advanced and all outputs compared afterwards.
    task automatic step(input bit init, input bit halt, input bit ret, input bit call,
                        input bit jmp, input bit cond, input logic [7:0] addr);
        logic       ob, oh;
        logic [7:0] ot, cur_pc;
        Init = init; IsHalt = halt; IsRet = ret; IsCall = call;
        IsJmp = jmp; Cond = cond; Addr = addr; PC = pc_m;
        cur_pc = pc_m;
        ob = exp_b; oh = exp_h; ot = exp_t;
        @(posedge CLK);
        #1;
        if (init) begin
            exp_b = 0; exp_t = 0; exp_h = 0; exp_e = 0; exp_cnt = 0;
            ras_q.delete();
        end else begin
`ifdef BRANCH_CTRL_COUNT_EN
            if (ob && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            if (oh) begin
                exp_b = 0;                       // parked until Init
            end else if (ob) begin
                exp_b = 0;                       // slot after a transfer: inputs ignored
            end else begin
                exp_b = 0;
                if (halt) begin
                    exp_h = 1;
                end else if (ret) begin
                    if (ras_q.size() > 0) begin
                        exp_t = ras_q.pop_back() + 8'd1;
                        exp_b = 1;
                    end else begin
                        exp_e = 1; exp_h = 1;
                    end
                end else if (call) begin
                    if (ras_q.size() < DEPTH) begin
                        ras_q.push_back(cur_pc + 8'd1);
                        exp_t = addr + 8'd1;
                        exp_b = 1;
                    end else begin
                        exp_e = 1; exp_h = 1;
                    end
                end else if (jmp && cond) begin
                    exp_t = addr + 8'd1;
                    exp_b = 1;
                end
            end
        end
        // IF behaviour, driven by the values visible before this edge
        if (init) pc_m = 8'h0;
        else if (oh) pc_m = cur_pc;
        else if (ob) pc_m = ot - 8'd1;
        else pc_m = cur_pc + 8'd1;
        chk("Branch", Branch, exp_b);
        chk("Target", Target, exp_t);
        chk("Halt", Halt, exp_h);
        chk("Depth", Depth, ras_q.size());
        chk("StackErr", StackErr, exp_e);
        chk("BranchCount", BranchCount, exp_cnt);
        $display("step init=%0b h=%0b r=%0b c=%0b j=%0b cond=%0b addr=%h | B=%0b T=%h H=%0b D=%0d E=%0b N=%0d",
                 init, halt, ret, call, jmp, cond, addr, Branch, Target, Halt, Depth, StackErr, BranchCount);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("rst_branch", Branch, 1'b0);
        chk("rst_halt", Halt, 1'b0);
        chk("rst_depth", Depth, 3'd0);

        // Taken jump at PC=05
        pc_m = 8'h05;
        step(0, 0, 0, 0, 1, 1, 8'h20);
        chk("jmp_branch", Branch, 1'b1);
        chk("jmp_target", Target, 8'h21);
        idle();
        chk("jmp_flush_branch", Branch, 1'b0);
        chk("jmp_pc_dest", pc_m, 8'h20);

        // Not-taken jump
        step(0, 0, 0, 0, 1, 0, 8'h20);
        chk("nt_branch", Branch, 1'b0);

        // Call / return
        pc_m = 8'h10;
        step(0, 0, 0, 1, 0, 0, 8'h40);
        chk("call_target", Target, 8'h41);
        chk("call_depth", Depth, 3'd1);
        idle();
        idle();
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("ret_target", Target, 8'h12);
        chk("ret_depth", Depth, 3'd0);
        idle();

        // Five nested calls overflow the stack
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 0, 8'h50 + 8'(i));
            if (i < 4) idle();
        end
        chk("ovf_err", StackErr, 1'b1);
        chk("ovf_halt", Halt, 1'b1);
        chk("ovf_depth", Depth, 3'd4);
        chk("ovf_branch", Branch, 1'b0);
        step(0, 0, 0, 0, 1, 1, 8'h33);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("ovf_held", Halt, 1'b1);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("halted_init_halt", Halt, 1'b0);
        chk("halted_init_err", StackErr, 1'b0);
        chk("halted_init_cnt", BranchCount, 16'h0);

        // Return on empty stack
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("udf_err", StackErr, 1'b1);
        chk("udf_halt", Halt, 1'b1);
        step(1, 0, 0, 0, 0, 0, 8'h00);

        // Jump during the flush slot is ignored
        step(0, 0, 0, 0, 1, 1, 8'h70);
        step(0, 0, 0, 0, 1, 1, 8'h90);
        chk("flush_ignore", Branch, 1'b0);
        chk("flush_target", Target, 8'h71);

        // Init during flush
        step(0, 0, 0, 0, 1, 1, 8'h44);
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("flush_init_branch", Branch, 1'b0);
        chk("flush_init_target", Target, 8'h00);
        chk("flush_init_cnt", BranchCount, 16'h0);

        // Address wrap
        pc_m = 8'hFF;
        step(0, 0, 0, 1, 0, 0, 8'hFF);
        chk("wrap_target", Target, 8'h00);
        idle();
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("wrap_ret", Target, 8'h01);
        idle();

        // Halt instruction
        step(0, 1, 1, 1, 1, 1, 8'h12);
        chk("halt_instr", Halt, 1'b1);
        chk("halt_no_err", StackErr, 1'b0);
        step(1, 0, 0, 0, 0, 0, 8'h00);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit ri, rh;
            ri = ($urandom_range(0, 79) == 0);
            rh = ($urandom_range(0, 39) == 0);
            step(ri, rh, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
